// File: rtl/wegt_bram_arbiter.sv
// Shares six weight BRAM banks between the synapse bus and a single-word host port.
// Define WEGT_ARB_STARVE_GUARD_EN to force a host slot after MAX_WAIT busy cycles.
module wegt_bram_arbiter #(
    parameter int NUM_BANK  = 6,
    parameter int DWIDTH    = 64,
    parameter int AWIDTH    = 9,
    parameter int MEM_DEPTH = 432,
    parameter int MAX_WAIT  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_BANK*DWIDTH-1:0] i_syn_d,
    input  logic [NUM_BANK*AWIDTH-1:0] i_syn_addr,
    input  logic [NUM_BANK-1:0]        i_syn_ce,
    input  logic [NUM_BANK-1:0]        i_syn_we,
    output logic [NUM_BANK*DWIDTH-1:0] o_syn_q,
    output logic                       o_syn_stall,
    output logic [NUM_BANK*DWIDTH-1:0] d,
    output logic [NUM_BANK*AWIDTH-1:0] addr,
    output logic [NUM_BANK-1:0]        ce,
    output logic [NUM_BANK-1:0]        we,
    input  logic [NUM_BANK*DWIDTH-1:0] q,
    input  logic                       i_host_req,
    input  logic                       i_host_we,
    input  logic [2:0]                 i_host_bank,
    input  logic [AWIDTH-1:0]          i_host_addr,
    input  logic [DWIDTH-1:0]          i_host_wdata,
    output logic                       o_host_ready,
    output logic                       o_host_done,
    output logic                       o_host_err,
    output logic [DWIDTH-1:0]          o_host_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_ISSUE,
        S_RDAT
    } state_t;

    state_t              r_state;
    logic [2:0]          r_bank;
    logic [AWIDTH-1:0]   r_addr;
    logic                r_we;
    logic [DWIDTH-1:0]   r_wdata;
    logic                r_ready;
    logic                r_done;
    logic                r_err;
    logic [DWIDTH-1:0]   r_rdata;

    logic                w_busy;
    logic                w_bad;
    logic                w_issue;
    logic [DWIDTH-1:0]   w_q_bank;

`ifdef WEGT_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0]       r_cnt;
    logic                r_stall;
    logic                w_force;

    assign w_force     = (r_cnt == CW'(MAX_WAIT));
    assign o_syn_stall = r_stall;
`else
    assign o_syn_stall = 1'b0;
`endif

    assign o_syn_q      = q;
    assign o_host_ready = r_ready;
    assign o_host_done  = r_done;
    assign o_host_err   = r_err;
    assign o_host_rdata = r_rdata;

    assign w_bad   = (32'(i_host_bank) >= NUM_BANK) ||
                     (32'(i_host_addr) >= MEM_DEPTH);
    // Reset drops the host override in the same cycle
    assign w_issue = (r_state == S_ISSUE) && !reset;

    always_comb begin
        w_busy   = 1'b0;
        w_q_bank = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (32'(r_bank) == b) begin
                w_busy   = i_syn_ce[b];
                w_q_bank = q[b*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        d    = i_syn_d;
        addr = i_syn_addr;
        ce   = i_syn_ce;
        we   = i_syn_we;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (w_issue && 32'(r_bank) == b) begin
                ce[b]                    = 1'b1;
                we[b]                    = r_we;
                addr[b*AWIDTH +: AWIDTH] = r_addr;
                d[b*DWIDTH +: DWIDTH]    = r_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_bank  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
`ifdef WEGT_ARB_STARVE_GUARD_EN
            r_cnt   <= '0;
            r_stall <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
`ifdef WEGT_ARB_STARVE_GUARD_EN
            r_stall <= 1'b0;
`endif
            unique case (r_state)
                S_IDLE: begin
                    if (r_ready && i_host_req) begin
                        r_bank  <= i_host_bank;
                        r_addr  <= i_host_addr;
                        r_we    <= i_host_we;
                        r_wdata <= i_host_wdata;
                        r_ready <= 1'b0;
                        if (w_bad) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else begin
                            r_state <= S_PEND;
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_PEND: begin
`ifdef WEGT_ARB_STARVE_GUARD_EN
                    if (!w_busy || w_force) begin
                        r_state <= S_ISSUE;
                        r_cnt   <= '0;
                        r_stall <= w_busy;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`else
                    if (!w_busy) begin
                        r_state <= S_ISSUE;
                    end
`endif
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RDAT;
                    end
                end
                S_RDAT: begin
                    r_rdata <= w_q_bank;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wegt_bram_arbiter.sv
// Bench for wegt_bram_arbiter: BRAM model, timestamp-based host model, directed host traffic.
module tb_wegt_bram_arbiter;

    localparam int NB    = 6;
    localparam int DW    = 64;
    localparam int AW    = 9;
    localparam int DEPTH = 432;
    localparam int MW    = 16;
    localparam int WB    = NB * DW;

    logic              clk = 1'b0;
    logic              reset;
    logic [NB*DW-1:0]  i_syn_d;
    logic [NB*AW-1:0]  i_syn_addr;
    logic [NB-1:0]     i_syn_ce;
    logic [NB-1:0]     i_syn_we;
    logic [NB*DW-1:0]  o_syn_q;
    logic              o_syn_stall;
    logic [NB*DW-1:0]  d;
    logic [NB*AW-1:0]  addr;
    logic [NB-1:0]     ce;
    logic [NB-1:0]     we;
    logic [NB*DW-1:0]  q;
    logic              i_host_req;
    logic              i_host_we;
    logic [2:0]        i_host_bank;
    logic [AW-1:0]     i_host_addr;
    logic [DW-1:0]     i_host_wdata;
    logic              o_host_ready;
    logic              o_host_done;
    logic              o_host_err;
    logic [DW-1:0]     o_host_rdata;

    always #5 clk = ~clk;

    wegt_bram_arbiter #(
        .NUM_BANK(NB), .DWIDTH(DW), .AWIDTH(AW), .MEM_DEPTH(DEPTH), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .reset(reset),
        .i_syn_d(i_syn_d), .i_syn_addr(i_syn_addr),
        .i_syn_ce(i_syn_ce), .i_syn_we(i_syn_we),
        .o_syn_q(o_syn_q), .o_syn_stall(o_syn_stall),
        .d(d), .addr(addr), .ce(ce), .we(we), .q(q),
        .i_host_req(i_host_req), .i_host_we(i_host_we),
        .i_host_bank(i_host_bank), .i_host_addr(i_host_addr),
        .i_host_wdata(i_host_wdata),
        .o_host_ready(o_host_ready), .o_host_done(o_host_done),
        .o_host_err(o_host_err), .o_host_rdata(o_host_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int b, input int a);
        return {16'(b), 16'(a), 32'hC0DE_0000};
    endfunction

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // spbram stand-ins: registered read, write-no-read
    logic mem_init;
    logic [DW-1:0] mem [NB][DEPTH];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_init) begin
                for (int a = 0; a < DEPTH; a++) mem[b][a] <= init_word(b, a);
            end else if (ce[b]) begin
                if (we[b]) mem[b][int'(addr[b*AW +: AW])] <= d[b*DW +: DW];
                else q[b*DW +: DW] <= mem[b][int'(addr[b*AW +: AW])];
            end
        end
    end

    // synapse traffic: 0 idle, 1 one bank held busy, 2 write stream on all banks but 1
    int syn_mode = 0;
    int syn_bank = 3;
    int syn_until = 0;
    task automatic drive_syn();
        i_syn_ce = '0;
        i_syn_we = '0;
        for (int b = 0; b < NB; b++) begin
            i_syn_addr[b*AW +: AW] = AW'((cyc * 7 + b * 31) % DEPTH);
            i_syn_d[b*DW +: DW] = {32'(cyc), 32'(b)} ^ 64'hA5A5_0000_0000_5A5A;
            if (syn_mode == 1 && b == syn_bank && cyc < syn_until) i_syn_ce[b] = 1'b1;
            if (syn_mode == 2 && b != 1) begin
                i_syn_ce[b] = 1'b1;
                i_syn_we[b] = 1'b1;
            end
        end
    endtask
    always @(posedge clk) begin
        #1;
        drive_syn();
    end

    // model: one host transaction described by its cycle stamps
    logic [DW-1:0] gold [NB][DEPTH];
    bit            m_busy = 0;
    bit            m_valid, m_we, m_err;
    int            m_treq = -1, m_issue = -1, m_done = -1, m_stall = -1;
    int            m_bank, m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [NB-1:0] ece, ewe;
    logic [NB*AW-1:0] eaddr;
    logic [NB*DW-1:0] ed;
    bit            rdy, edone;
    int            stall_cnt = 0, stall_at = -1;

    always @(negedge clk) begin
        if (mem_init) begin
            for (int b = 0; b < NB; b++)
                for (int a = 0; a < DEPTH; a++) gold[b][a] = init_word(b, a);
        end
        if (!reset && m_busy && m_valid && m_issue < 0 && cyc > m_treq) begin
            if (!i_syn_ce[m_bank]) m_issue = cyc + 1;
`ifdef WEGT_ARB_STARVE_GUARD_EN
            else if (cyc - (m_treq + 1) == MW) begin
                m_issue = cyc + 1;
                m_stall = cyc + 1;
            end
`endif
            if (m_issue >= 0) m_done = m_issue + (m_we ? 1 : 2);
        end
        ece = i_syn_ce;
        ewe = i_syn_we;
        eaddr = i_syn_addr;
        ed = i_syn_d;
        if (!reset && m_busy && cyc == m_issue) begin
            ece[m_bank] = 1'b1;
            ewe[m_bank] = m_we;
            eaddr[m_bank*AW +: AW] = AW'(m_addr);
            ed[m_bank*DW +: DW] = m_wdata;
            if (!m_we) m_rdata = gold[m_bank][m_addr];
        end
        for (int b = 0; b < NB; b++)
            if (ece[b] && ewe[b]) gold[b][int'(eaddr[b*AW +: AW])] = ed[b*DW +: DW];
        if (!mem_init) begin
            chk("bus_ce", WB'(ce), WB'(ece));
            chk("bus_we", WB'(we), WB'(ewe));
            chk("bus_addr", WB'(addr), WB'(eaddr));
            chk("bus_d", d, ed);
        end
        if (reset) begin
            m_busy = 0;
            m_treq = -1; m_issue = -1; m_done = -1; m_stall = -1;
        end else begin
            chk("syn_q", o_syn_q, q);
            rdy = !(m_busy && cyc > m_treq && (m_done < 0 || cyc <= m_done));
            edone = m_busy && cyc == m_done;
            chk("ready", WB'(o_host_ready), WB'(rdy));
            chk("done", WB'(o_host_done), WB'(edone));
            chk("err", WB'(o_host_err), WB'(edone && m_err));
            chk("stall", WB'(o_syn_stall), WB'(m_busy && cyc == m_stall));
            if (edone && !m_err && !m_we) chk("rdata", WB'(o_host_rdata), WB'(m_rdata));
            if (o_syn_stall) begin
                stall_cnt++;
                stall_at = cyc;
            end
            if (rdy && i_host_req) begin
                m_busy = 1;
                m_treq = cyc;
                m_bank = int'(i_host_bank);
                m_addr = int'(i_host_addr);
                m_we = i_host_we;
                m_wdata = i_host_wdata;
                m_valid = m_bank < NB && m_addr < DEPTH;
                m_err = !m_valid;
                m_issue = -1;
                m_stall = -1;
                m_done = m_valid ? -1 : cyc + 1;
            end
        end
    end

    int t_last;
    task automatic host(input bit w, input int bk, input int a, input logic [DW-1:0] wd,
                        output int lat, output bit e);
        int n;
        lat = -1;
        e = 0;
        n = 0;
        @(negedge clk);
        while (!o_host_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("host_ready_wait", WB'(o_host_ready), WB'(1));
        @(posedge clk);
        #1;
        i_host_req = 1'b1;
        i_host_we = w;
        i_host_bank = 3'(bk);
        i_host_addr = AW'(a);
        i_host_wdata = wd;
        t_last = cyc;
        @(posedge clk);
        #1;
        i_host_req = 1'b0;
        n = 0;
        @(negedge clk);
        while (!o_host_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("host_done_wait", WB'(o_host_done), WB'(1));
        if (o_host_done) begin
            lat = cyc - t_last;
            e = o_host_err;
        end
    endtask

    task automatic watch_no_done(input string name, input int ncyc);
        int seen;
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (o_host_done) seen++;
        end
        chk(name, WB'(seen), WB'(0));
    endtask

    int lat;
    bit e;
    int mism;

    initial begin
        mem_init = 1'b1;
        reset = 1'b1;
        i_host_req = 1'b0;
        i_host_we = 1'b0;
        i_host_bank = '0;
        i_host_addr = '0;
        i_host_wdata = '0;
        drive_syn();
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", WB'(o_host_ready), WB'(1));
        chk("rst_done", WB'(o_host_done), WB'(0));
        chk("rst_err", WB'(o_host_err), WB'(0));
        chk("rst_rdata", WB'(o_host_rdata), WB'(0));
        chk("rst_stall", WB'(o_syn_stall), WB'(0));

        host(1, 2, 5, 64'h0001_0002_0003_0004, lat, e);
        chk("wr_latency", WB'(lat), WB'(3));
        chk("wr_err", WB'(e), WB'(0));
        chk("wr_mem", WB'(mem[2][5]), WB'(64'h0001_0002_0003_0004));
        host(0, 2, 5, 64'h0, lat, e);
        chk("rd_latency", WB'(lat), WB'(4));
        chk("rd_data", WB'(o_host_rdata), WB'(64'h0001_0002_0003_0004));

        host(1, 6, 0, 64'h1111, lat, e);
        chk("bad_bank_lat", WB'(lat), WB'(1));
        chk("bad_bank_err", WB'(e), WB'(1));
        host(0, 0, 432, 64'h0, lat, e);
        chk("bad_addr_lat", WB'(lat), WB'(1));
        chk("bad_addr_err", WB'(e), WB'(1));
        host(1, 7, 500, 64'h2222, lat, e);
        chk("bad_both_err", WB'(e), WB'(1));
        host(0, 0, 431, 64'h0, lat, e);
        chk("edge_addr_err", WB'(e), WB'(0));
        chk("edge_addr_data", WB'(o_host_rdata), WB'(64'h0000_01AF_C0DE_0000));

        @(negedge clk);
        stall_cnt = 0;
        syn_bank = 3;
        syn_until = cyc + 2 + 40;
        syn_mode = 1;
        host(0, 3, 10, 64'h0, lat, e);
`ifdef WEGT_ARB_STARVE_GUARD_EN
        chk("cont_latency", WB'(lat), WB'(20));
        chk("cont_stall_cnt", WB'(stall_cnt), WB'(1));
        chk("cont_stall_at", WB'(stall_at - t_last), WB'(18));
`else
        chk("cont_latency", WB'(lat), WB'(43));
        chk("cont_stall_cnt", WB'(stall_cnt), WB'(0));
`endif
        chk("cont_data", WB'(o_host_rdata), WB'(64'h0003_000A_C0DE_0000));
        while (cyc < syn_until + 1) @(negedge clk);
        syn_mode = 0;

        @(negedge clk);
        syn_mode = 2;
        host(1, 1, 100, 64'hDEAD_BEEF_0BAD_F00D, lat, e);
        chk("par_latency", WB'(lat), WB'(3));
        host(1, 1, 431, 64'h1234_5678_9ABC_DEF0, lat, e);
        chk("par_latency2", WB'(lat), WB'(3));
        repeat (5) @(negedge clk);
        syn_mode = 0;
        host(0, 1, 100, 64'h0, lat, e);
        chk("par_readback", WB'(o_host_rdata), WB'(64'hDEAD_BEEF_0BAD_F00D));

        @(negedge clk);
        syn_bank = 4;
        syn_until = cyc + 30;
        syn_mode = 1;
        @(posedge clk);
        #1;
        i_host_req = 1'b1;
        i_host_we = 1'b0;
        i_host_bank = 3'd4;
        i_host_addr = AW'(7);
        @(posedge clk);
        #1;
        i_host_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("pend_rst_ready", WB'(o_host_ready), WB'(1));
        watch_no_done("pend_rst_nodone", 10);
        host(1, 0, 3, 64'h0F0F_0F0F_F0F0_F0F0, lat, e);
        chk("pend_rst_new", WB'(lat), WB'(3));
        while (cyc < syn_until + 1) @(negedge clk);
        syn_mode = 0;

        @(posedge clk);
        #1;
        i_host_req = 1'b1;
        i_host_we = 1'b0;
        i_host_bank = 3'd0;
        i_host_addr = AW'(1);
        @(posedge clk);
        #1;
        i_host_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rdat_rst_ready", WB'(o_host_ready), WB'(1));
        chk("rdat_rst_rdata", WB'(o_host_rdata), WB'(0));
        watch_no_done("rdat_rst_nodone", 8);
        host(0, 0, 3, 64'h0, lat, e);
        chk("rdat_rst_new", WB'(lat), WB'(4));
        chk("rdat_rst_data", WB'(o_host_rdata), WB'(64'h0F0F_0F0F_F0F0_F0F0));

        repeat (3) @(negedge clk);
        for (int b = 0; b < NB; b++) begin
            mism = 0;
            for (int a = 0; a < DEPTH; a++)
                if (mem[b][a] !== gold[b][a]) mism++;
            chk($sformatf("mem_bank%0d", b), WB'(mism), WB'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wegt_bram_arbiter.md
# wegt_bram_arbiter

Shares the six single-port weight BRAMs (spbram, 64-bit × 432) between the synapse datapath and a host weight-load/readback port. The synapse engine keeps priority per bank. Single host word accesses (one bank, one address) are slotted into cycles where that bank's synapse `ce` is low. The block sits between `synapse` and the `spbram` instances; the synapse BRAM bus passes straight through whenever no host access is issuing.

## Interface
Parameters:
- `NUM_BANK`, 6, number of weight BRAM banks
- `DWIDTH`, 64, bank data width (4 × 16-bit weights)
- `AWIDTH`, 9, bank address width
- `MEM_DEPTH`, 432, valid words per bank
- `MAX_WAIT`, 16, starvation limit in cycles (used only with the guard macro)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `i_syn_d`  in  NUM_BANK*DWIDTH  synapse write data
- `i_syn_addr`  in  NUM_BANK*AWIDTH  synapse addresses
- `i_syn_ce` / `i_syn_we`  in  NUM_BANK  synapse enables
- `o_syn_q`  out  NUM_BANK*DWIDTH  read data to synapse (wired from `q`)
- `o_syn_stall`  out  1  synapse access to the forced bank is dropped this cycle
- `d`, `addr`, `ce`, `we`  out  BRAM-side buses, same widths as the `i_syn_*` inputs
- `q`  in  NUM_BANK*DWIDTH  BRAM read data
- `i_host_req`  in  1  host request
- `i_host_we`  in  1  host request is a write
- `i_host_bank`  in  3  target bank
- `i_host_addr`  in  AWIDTH  target word
- `i_host_wdata`  in  DWIDTH  write data
- `o_host_ready`  out  1  request can be accepted
- `o_host_done`  out  1  one-cycle pulse when the access completes
- `o_host_err`  out  1  qualifies `o_host_done`: request was rejected
- `o_host_rdata`  out  DWIDTH  read data, valid with `o_host_done` for reads

## Operation
- FSM states: IDLE, PEND, ISSUE, RDAT.
- **IDLE**
  - `o_host_ready`=1.
  - When `i_host_req`=1, capture bank, addr, we and wdata into registers.
  - If bank ≥ NUM_BANK or addr ≥ MEM_DEPTH: next state IDLE, with `o_host_done`=1 and `o_host_err`=1 in the following cycle. No BRAM access occurs.
  - Otherwise next state PEND.
- **PEND**
  - If `i_syn_ce[bank]`=0 in this cycle, go to ISSUE.
  - Otherwise stay and increment the wait counter.
- **ISSUE** (one cycle)
  - Bank `bank` is driven from the captured request: `ce`=1, `we`=captured we, `addr`, `d`.
  - All other banks keep passing through from the synapse.
  - Write: go to IDLE, `o_host_done`=1 in the next cycle.
  - Read: go to RDAT.
- **RDAT**
  - `o_host_rdata` ← `q[bank]`.
  - `o_host_done`=1 in the following cycle; next state IDLE.
- A bank conflict is decided combinationally from the current-cycle `i_syn_ce`. The synapse is never blocked unless the guard is compiled in.
- `o_syn_q` = `q` always. Synapse read data on a bank accessed by the host is don't-care, because the synapse did not issue there.
- `reset` in any state:
  - Returns the FSM to IDLE and clears the counter and `o_host_done`/`o_host_err`.
  - An in-flight host access is abandoned, with no done pulse.
  - The BRAM buses revert to pure pass-through in the same cycle.

## Timing
- Reset values: `o_host_ready`=1, `o_host_done`=0, `o_host_err`=0, `o_host_rdata`=0, `o_syn_stall`=0. `d`/`addr`/`ce`/`we` equal the synapse inputs.
- Uncontended write: req at cycle T, ISSUE at T+2, done at T+3.
- Uncontended read: req at T, ISSUE at T+2, BRAM `q` at T+3, rdata registered and done at T+4.
- Error path: done+err at T+1.
- `o_host_ready`=0 from the cycle after acceptance until the cycle after the done pulse.
- Host inputs are ignored outside IDLE.

## Configuration
- `WEGT_ARB_STARVE_GUARD_EN` defined:
  - When the PEND counter reaches MAX_WAIT, the next cycle is ISSUE regardless of `i_syn_ce[bank]`.
  - In that cycle `o_syn_stall`=1 and the synapse access to that bank is suppressed (`ce[bank]` carries the host access). The synapse must re-present that access.
  - The counter clears on leaving PEND.
- Undefined: strict synapse priority. PEND waits indefinitely, `o_syn_stall` is tied 0, and no counter logic exists.

## Test plan
- **Idle synapse, write:** host writes bank 2, addr 5, 0x0001_0002_0003_0004. Expect done at T+3, no err, `u_TDPBRAM_2.ram[5]` equals the data, banks 0/1/3/4/5 untouched.
- **Readback:** host reads bank 2, addr 5 after the write. Expect done at T+4 with `o_host_rdata`=0x0001_0002_0003_0004.
- **Error requests:**
  - Bank 6 → err.
  - Addr 432 on bank 0 → err.
  - Both: done+err at T+1, `ce` never asserted by the host.
- **Contention:** synapse holds `ce[3]`=1 for 40 cycles while host reads bank 3.
  - Guard off: ISSUE in the first cycle after `ce[3]` drops, no `o_syn_stall`.
  - Guard on (MAX_WAIT=16): `o_syn_stall`=1 for exactly one cycle, 17 cycles after entering PEND.
- **Parallel banks:** synapse streams banks 0–5 except bank 1 while host writes bank 1. No synapse access is dropped and the synapse data in banks 0, 2–5 matches a golden image.
- **Reset mid-operation:** assert `reset` in PEND and in RDAT. No done pulse follows, `o_host_ready`=1 the next cycle, and a new request then completes normally.
